// File: rtl/regfile_read_arbiter.sv
// rtl/regfile_read_arbiter.sv - round-robin arbiter sharing one register-file read port with a registered response slot
module regfile_read_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0][4:0]  req_addr,
    output logic [NREQ-1:0]       req_ready,
    output logic [4:0]            rd_sel,
    input  logic [WIDTH-1:0]      rd_data,
    input  logic                  wr_en,
    input  logic [4:0]            wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    input  logic                  rsp_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   cand;
    logic [IDW-1:0]   gidx;
    logic             grant_any;
    logic             stall;
    logic [4:0]       gaddr;
    logic [WIDTH-1:0] cap_data;

    assign stall = (state_q == FULL) && !rsp_ready;

    // Round-robin search starting at ptr; nothing is granted while stalled or in reset
    always_comb begin
        grant_any = 1'b0;
        gidx      = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NREQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                gidx      = cand;
            end
        end
        if (stall || !reset_n) begin
            grant_any = 1'b0;
        end
    end

    // Value to capture: XZR reads zero, a same-edge write to the granted register is forwarded
    always_comb begin
        gaddr = req_addr[gidx];
        if (gaddr == 5'd31) begin
            cap_data = '0;
        end else if (wr_en && (wr_addr == gaddr)) begin
            cap_data = wr_data;
        end else begin
            cap_data = rd_data;
        end
    end

    // Slot state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot next state: a grant always refills; otherwise the slot stays full only while stalled
    always_comb begin
        state_d = EMPTY;
        if (grant_any) begin
            state_d = FULL;
        end else if (stall) begin
            state_d = FULL;
        end
    end

    // Slot outputs, one-hot grant and read-mux select
    always_comb begin
        rsp_valid = (state_q == FULL);
        req_ready = '0;
        rd_sel    = 5'd0;
        if (grant_any) begin
            req_ready[gidx] = 1'b1;
            rd_sel          = gaddr;
        end
    end

    // Response payload and round-robin pointer update on each grant
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q    <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
        end else if (grant_any) begin
            ptr_q    <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + IDW'(1);
            rsp_id   <= gidx;
            rsp_data <= cap_data;
        end
    end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// tb/tb_regfile_read_arbiter.sv - self-checking bench for regfile_read_arbiter
module tb_regfile_read_arbiter;

    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int WIDTH = 64;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0][4:0] req_addr;
    logic [NREQ-1:0]      req_ready;
    logic [4:0]           rd_sel;
    logic [WIDTH-1:0]     rd_data;
    logic                 wr_en;
    logic [4:0]           wr_addr;
    logic [WIDTH-1:0]     wr_data;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [WIDTH-1:0]     rsp_data;
    logic                 rsp_ready;

    logic [WIDTH-1:0]     regs [32];

    int                   n_checks = 0;
    int                   n_fails  = 0;

    int                   m_ptr   = 0;
    bit                   m_valid = 1'b0;
    int                   m_id    = 0;
    logic [WIDTH-1:0]     m_data  = '0;

    always #5 clk = ~clk;

    assign rd_data = regs[rd_sel];

    regfile_read_arbiter #(.NREQ(NREQ), .IDW(IDW), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle against the reference model; inputs are already applied by the caller
    task automatic cycle();
        int               g;
        bit               stl;
        logic [4:0]       a;
        logic [WIDTH-1:0] v;
        logic [63:0]      exp_ready;
        @(negedge clk);
        stl = m_valid && !rsp_ready;
        g   = -1;
        if (reset_n && !stl) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
        end
        exp_ready = (g < 0) ? 64'd0 : (64'd1 << g);
        a = (g < 0) ? 5'd0 : req_addr[g];
        check("req_ready", 64'(req_ready), exp_ready);
        check("rd_sel", 64'(rd_sel), 64'(a));
        if (a == 5'd31)                     v = '0;
        else if (wr_en && wr_addr == a)     v = wr_data;
        else                                v = regs[a];
        @(posedge clk);
        if (!reset_n) begin
            m_valid = 1'b0; m_ptr = 0; m_id = 0; m_data = '0;
        end else if (g >= 0) begin
            m_valid = 1'b1; m_id = g; m_data = v; m_ptr = (g + 1) % NREQ;
        end else if (m_valid && rsp_ready) begin
            m_valid = 1'b0;
        end
        if (wr_en && wr_addr != 5'd31) regs[wr_addr] = wr_data;
        #1;
        check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
        check("rsp_id", 64'(rsp_id), 64'(m_id));
        check("rsp_data", rsp_data, m_data);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
        regs[5]  = 64'h5;
        regs[31] = '1;
        req_addr  = '0;
        wr_en     = 1'b0;
        wr_addr   = 5'd0;
        wr_data   = '0;
        rsp_ready = 1'b1;

        // reset with every requester asking
        reset_n   = 1'b0;
        req_valid = 4'b1111;
        cycle();
        cycle();

        // round-robin after reset: 0,1,2,3,0,1
        reset_n = 1'b1;
        for (int i = 0; i < NREQ; i++) req_addr[i] = 5'(i + 1);
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("rr_id", 64'(rsp_id), 64'(i % NREQ));
        end

        // single read of register 5
        req_valid   = 4'b0001;
        req_addr[0] = 5'd5;
        cycle();
        check("single_data", rsp_data, 64'h5);
        check("single_id", 64'(rsp_id), 64'd0);

        // backpressure with slot owned by requester 1
        req_valid = 4'b1111;
        cycle();
        check("bp_owner", 64'(rsp_id), 64'd1);
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        rsp_ready = 1'b1;
        cycle();
        check("bp_next", 64'(rsp_id), 64'd2);

        // XZR then forwarding
        req_valid   = 4'b0001;
        req_addr[0] = 5'd31;
        cycle();
        check("xzr", rsp_data, 64'd0);
        regs[7]     = 64'h1;
        req_addr[0] = 5'd7;
        wr_en       = 1'b1;
        wr_addr     = 5'd7;
        wr_data     = 64'hDEAD;
        cycle();
        check("fwd", rsp_data, 64'hDEAD);
        wr_en = 1'b0;

        // reset while full and stalled, then order restarts at 0
        req_valid = 4'b1111;
        cycle();
        rsp_ready = 1'b0;
        cycle();
        reset_n = 1'b0;
        cycle();
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            cycle();
            check("post_rst_id", 64'(rsp_id), 64'(i));
        end

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            reset_n   = ($urandom_range(0, 49) != 0);
            req_valid = 4'($urandom);
            for (int i = 0; i < NREQ; i++) req_addr[i] = 5'($urandom_range(0, 31));
            rsp_ready = ($urandom_range(0, 3) != 0);
            wr_en     = $urandom_range(0, 1) == 1;
            wr_addr   = ($urandom_range(0, 1) == 1) ? req_addr[$urandom_range(0, NREQ - 1)]
                                                    : 5'($urandom_range(0, 31));
            wr_data   = {$urandom, $urandom};
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
